jk_excitation_encoder: RTL and testbench

JK_EXCITATION_ENCODER -- requirements
Module: jk_excitation_encoder

---
 rtl/jkx_pkg.sv | 26 ++
 rtl/jk_using_d.sv | 33 +++
 rtl/jk_excitation_encoder.sv | 116 +++++++++++
 tb/tb_jk_excitation_encoder.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/jkx_pkg.sv
// Shared FSM state type and JK excitation codes ({J,K}) for the JK excitation encoder.
package jkx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        APPLY,
        CHECK
    } state_t;

    localparam logic [1:0] JK_HOLD = 2'b00;
    localparam logic [1:0] JK_CLR  = 2'b01;
    localparam logic [1:0] JK_SET  = 2'b10;
    localparam logic [1:0] JK_TGL  = 2'b11;

    // Minimal set/clear excitation that drives q toward t.
    function automatic logic [1:0] jk_excite(input logic q, input logic t);
        logic [1:0] jk;
        case ({q, t})
            2'b01:   jk = JK_SET;
            2'b10:   jk = JK_CLR;
            default: jk = JK_HOLD;
        endcase
        return jk;
    endfunction

endpackage

// File: rtl/jk_using_d.sv
// One bank bit: JK flip-flop built from a D flop with clock enable and synchronous active-low reset.
module jk_using_d (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic j,
    input  logic k,
    output logic q,
    output logic qbar
);

    logic q_q;
    logic q_d;

    always_comb begin
        q_d = q_q;
        if (en) begin
            q_d = (j & ~q_q) | (~k & q_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q    = q_q;
    assign qbar = ~q_q;

endmodule

// File: rtl/jk_excitation_encoder.sv
// Converts a requested bank state into JK excitation, applies it once, then checks the result.
// Build option JKX_TOGGLE_EN: changing bits are driven with J=K=1 instead of set/clear.
module jk_excitation_encoder
    import jkx_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tgt_valid,
    output logic             tgt_ready,
    input  logic [WIDTH-1:0] tgt_data,
    input  logic             hold,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic             done,
    output logic             err
);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   tgt_q, tgt_d;
    logic [WIDTH-1:0]   j_q, j_d;
    logic [WIDTH-1:0]   k_q, k_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               ready_q, ready_d;
    logic               bank_en;

    // Excitation is registered at capture time; q is stable throughout APPLY so it stays valid.
    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        j_d     = j_q;
        k_d     = k_q;
        done_d  = 1'b0;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                j_d = '0;
                k_d = '0;
                if (tgt_valid) begin
                    tgt_d   = tgt_data;
                    state_d = APPLY;
                    for (int unsigned i = 0; i < WIDTH; i++) begin
`ifdef JKX_TOGGLE_EN
                        {j_d[i], k_d[i]} = (q[i] ^ tgt_data[i]) ? JK_TGL : JK_HOLD;
`else
                        {j_d[i], k_d[i]} = jk_excite(q[i], tgt_data[i]);
`endif
                    end
                end
            end
            APPLY: begin
                if (!hold) begin
                    state_d = CHECK;
                    j_d     = '0;
                    k_d     = '0;
                    done_d  = 1'b1;
                end
            end
            CHECK: begin
                err_d   = err_q | (q != tgt_q);
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                j_d     = '0;
                k_d     = '0;
            end
        endcase
        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            tgt_q   <= '0;
            j_q     <= '0;
            k_q     <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            j_q     <= j_d;
            k_q     <= k_d;
            done_q  <= done_d;
            err_q   <= err_d;
            ready_q <= ready_d;
        end
    end

    assign bank_en = (state_q == APPLY) && !hold;

    for (genvar b = 0; b < WIDTH; b++) begin : g_bank
        jk_using_d u_bit (
            .clk  (clk),
            .reset(reset),
            .en   (bank_en),
            .j    (j_q[b]),
            .k    (k_q[b]),
            .q    (q[b]),
            .qbar (qbar[b])
        );
    end

    assign j         = j_q;
    assign k         = k_q;
    assign done      = done_q;
    assign err       = err_q;
    assign tgt_ready = ready_q;

endmodule

// File: tb/tb_jk_excitation_encoder.sv
// Directed bench for jk_excitation_encoder: reset, set/clear, no-change, hold, abort and ignored-input cases.
module tb_jk_excitation_encoder;

    logic       clk;
    logic       reset;
    logic       tgt_valid;
    logic       tgt_ready;
    logic [3:0] tgt_data;
    logic       hold;
    logic [3:0] j;
    logic [3:0] k;
    logic [3:0] q;
    logic [3:0] qbar;
    logic       done;
    logic       err;

    int unsigned tests_run;
    int unsigned tests_failed;

    jk_excitation_encoder #(.WIDTH(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .tgt_valid(tgt_valid),
        .tgt_ready(tgt_ready),
        .tgt_data (tgt_data),
        .hold     (hold),
        .j        (j),
        .k        (k),
        .q        (q),
        .qbar     (qbar),
        .done     (done),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b0;
        tgt_valid    = 1'b0;
        tgt_data     = 4'h0;
        hold         = 1'b0;

        tick();
        tick();
        chk("rst_ready", 32'(tgt_ready), 32'h1);
        chk("rst_q",     32'(q),         32'h0);
        chk("rst_qbar",  32'(qbar),      32'hF);
        chk("rst_done",  32'(done),      32'h0);
        chk("rst_err",   32'(err),       32'h0);
        chk("rst_j",     32'(j),         32'h0);
        chk("rst_k",     32'(k),         32'h0);
        reset = 1'b1;
        tick();
        chk("idle_ready", 32'(tgt_ready), 32'h1);

        // 0000 -> 1010
        tgt_valid = 1'b1;
        tgt_data  = 4'b1010;
        tick();
        tgt_valid = 1'b0;
        chk("t1_ready", 32'(tgt_ready), 32'h0);
`ifdef JKX_TOGGLE_EN
        chk("t1_j", 32'(j), 32'hA);
        chk("t1_k", 32'(k), 32'hA);
`else
        chk("t1_j", 32'(j), 32'hA);
        chk("t1_k", 32'(k), 32'h0);
`endif
        chk("t1_q_pre",  32'(q),    32'h0);
        chk("t1_done_a", 32'(done), 32'h0);
        tick();
        chk("t1_q",     32'(q),    32'hA);
        chk("t1_qbar",  32'(qbar), 32'h5);
        chk("t1_done",  32'(done), 32'h1);
        chk("t1_j_off", 32'(j),    32'h0);
        tick();
        chk("t1_done_end", 32'(done),      32'h0);
        chk("t1_ready_end", 32'(tgt_ready), 32'h1);
        chk("t1_err",      32'(err),       32'h0);

        // 1010 -> 0110
        tgt_valid = 1'b1;
        tgt_data  = 4'b0110;
        tick();
        tgt_valid = 1'b0;
`ifdef JKX_TOGGLE_EN
        chk("t2_j", 32'(j), 32'hC);
        chk("t2_k", 32'(k), 32'hC);
`else
        chk("t2_j", 32'(j), 32'h4);
        chk("t2_k", 32'(k), 32'h8);
`endif
        tick();
        chk("t2_q",    32'(q),    32'h6);
        chk("t2_done", 32'(done), 32'h1);
        tick();
        chk("t2_ready", 32'(tgt_ready), 32'h1);
        chk("t2_err",   32'(err),       32'h0);

        // target equals q
        tgt_valid = 1'b1;
        tgt_data  = 4'b0110;
        tick();
        tgt_valid = 1'b0;
        chk("t3_ready", 32'(tgt_ready), 32'h0);
        chk("t3_j",     32'(j),         32'h0);
        chk("t3_k",     32'(k),         32'h0);
        tick();
        chk("t3_done", 32'(done), 32'h1);
        chk("t3_q",    32'(q),    32'h6);
        tick();
        chk("t3_done_end", 32'(done),      32'h0);
        chk("t3_ready_end", 32'(tgt_ready), 32'h1);
        chk("t3_err",      32'(err),       32'h0);

        // 0110 -> 1001 with hold high for three APPLY edges
        tgt_valid = 1'b1;
        tgt_data  = 4'b1001;
        hold      = 1'b1;
        tick();
        tgt_valid = 1'b0;
`ifdef JKX_TOGGLE_EN
        chk("t4_j", 32'(j), 32'hF);
        chk("t4_k", 32'(k), 32'hF);
`else
        chk("t4_j", 32'(j), 32'h9);
        chk("t4_k", 32'(k), 32'h6);
`endif
        for (int n = 0; n < 3; n++) begin
            tick();
            chk("t4_hold_q",    32'(q),         32'h6);
            chk("t4_hold_done", 32'(done),      32'h0);
            chk("t4_hold_rdy",  32'(tgt_ready), 32'h0);
        end
`ifdef JKX_TOGGLE_EN
        chk("t4_j_held", 32'(j), 32'hF);
`else
        chk("t4_j_held", 32'(j), 32'h9);
`endif
        hold = 1'b0;
        tick();
        chk("t4_q",    32'(q),    32'h9);
        chk("t4_done", 32'(done), 32'h1);
        tick();
        chk("t4_ready", 32'(tgt_ready), 32'h1);
        chk("t4_err",   32'(err),       32'h0);

        // reset while in APPLY
        tgt_valid = 1'b1;
        tgt_data  = 4'b0011;
        tick();
        tgt_valid = 1'b0;
        chk("t5_in_apply", 32'(tgt_ready), 32'h0);
        reset = 1'b0;
        tick();
        chk("t5_q",     32'(q),         32'h0);
        chk("t5_qbar",  32'(qbar),      32'hF);
        chk("t5_done",  32'(done),      32'h0);
        chk("t5_j",     32'(j),         32'h0);
        chk("t5_k",     32'(k),         32'h0);
        chk("t5_ready", 32'(tgt_ready), 32'h1);
        reset = 1'b1;
        tick();
        chk("t5_done_after",  32'(done),      32'h0);
        chk("t5_ready_after", 32'(tgt_ready), 32'h1);
        chk("t5_q_after",     32'(q),         32'h0);

        // changing tgt_valid/tgt_data mid-operation is ignored
        tgt_valid = 1'b1;
        tgt_data  = 4'b1100;
        tick();
        tgt_data  = 4'b0011;
        chk("t6_ready_apply", 32'(tgt_ready), 32'h0);
        tick();
        tgt_data  = 4'b0101;
        chk("t6_ready_check", 32'(tgt_ready), 32'h0);
        chk("t6_done",        32'(done),      32'h1);
        chk("t6_q",           32'(q),         32'hC);
        tgt_valid = 1'b0;
        tick();
        chk("t6_ready_end", 32'(tgt_ready), 32'h1);
        chk("t6_q_end",     32'(q),         32'hC);
        chk("t6_err",       32'(err),       32'h0);
        tick();
        chk("t6_q_idle",    32'(q),    32'hC);
        chk("t6_done_idle", 32'(done), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
